// File: rtl/alu_issue_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : alu_issue_capture
//  Description : Issue/capture stage around a combinational 4-bit add/sub
//                datapath. Accepts one op per handshake, holds it on dp_*
//                for a settle window, samples the result, checks it against
//                a golden sum and hands it downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8,
    parameter int TXN_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_a,
    input  logic [3:0]           in_b,
    input  logic [1:0]           in_s,
    input  logic                 in_cin,
    output logic [3:0]           dp_a,
    output logic [3:0]           dp_b,
    output logic [1:0]           dp_s,
    output logic                 dp_cin,
    input  logic [3:0]           dp_d,
    input  logic                 dp_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_d,
    output logic                 out_cout,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [TXN_CNT_W-1:0] txn_count
);

    // Counter must hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, out_valid_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           dp_a_q, dp_b_q;
    logic [1:0]           dp_s_q;
    logic                 dp_cin_q;
    logic [4:0]           golden_q;
    logic [3:0]           out_d_q;
    logic                 out_cout_q, out_err_q;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic [TXN_CNT_W-1:0] txn_count_q;

    logic                 accept, sample, out_hs, mismatch;
    logic [3:0]           y_sel;
    logic [4:0]           golden_d;

    // Handshake qualifiers and the golden sum for the op being accepted.
    always_comb begin
        accept   = in_valid && in_ready_q;
        sample   = (state_q == S_SETTLE) && (cnt_q == '0);
        out_hs   = out_valid_q && out_ready;
        mismatch = ({dp_cout, dp_d} != golden_q);
        case (in_s)
            2'b00:   y_sel = in_b;
            2'b01:   y_sel = ~in_b;
            2'b10:   y_sel = 4'h0;
            default: y_sel = 4'hF;
        endcase
        golden_d = {1'b0, in_a} + {1'b0, y_sel} + {4'b0000, in_cin};
    end

    // Next-state logic for IDLE -> SETTLE -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETTLE;
            S_SETTLE: if (sample) state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register; ready/valid are registered decodes of the next state so
    // in_ready stays low through reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    // Operand capture, settle countdown, result sampling and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_s_q      <= '0;
            dp_cin_q    <= 1'b0;
            golden_q    <= '0;
            out_d_q     <= '0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            txn_count_q <= '0;
        end else begin
            if (accept) begin
                dp_a_q   <= in_a;
                dp_b_q   <= in_b;
                dp_s_q   <= in_s;
                dp_cin_q <= in_cin;
                golden_q <= golden_d;
                cnt_q    <= CNT_W'(SETTLE_CYCLES - 1);
            end else if ((state_q == S_SETTLE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (sample) begin
                out_d_q    <= dp_d;
                out_cout_q <= dp_cout;
                out_err_q  <= mismatch;
                if (mismatch && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                    err_count_q <= err_count_q + ERR_CNT_W'(1);
                end
            end
            if (out_hs) begin
                txn_count_q <= txn_count_q + TXN_CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_s      = dp_s_q;
    assign dp_cin    = dp_cin_q;
    assign out_d     = out_d_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;
    assign txn_count = txn_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_issue_capture
//  Description : Bench for alu_issue_capture with a behavioural datapath
//                (optionally stubbed to force dp_d=0) and a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_capture;

    localparam int SETTLE = 4;
    localparam int ERR_W  = 8;
    localparam int TXN_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [3:0]       in_a, in_b;
    logic [1:0]       in_s;
    logic             in_cin;
    logic [3:0]       dp_a, dp_b;
    logic [1:0]       dp_s;
    logic             dp_cin;
    logic [3:0]       dp_d;
    logic             dp_cout;
    logic             out_valid, out_ready;
    logic [3:0]       out_d;
    logic             out_cout, out_err;
    logic [ERR_W-1:0] err_count;
    logic [TXN_W-1:0] txn_count;

    logic             stub = 1'b0;
    logic [5:0]       exp_q[$];   // {err, cout, d}
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_capture #(
        .SETTLE_CYCLES(SETTLE),
        .ERR_CNT_W    (ERR_W),
        .TXN_CNT_W    (TXN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_s     (in_s),
        .in_cin   (in_cin),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_s     (dp_s),
        .dp_cin   (dp_cin),
        .dp_d     (dp_d),
        .dp_cout  (dp_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d    (out_d),
        .out_cout (out_cout),
        .out_err  (out_err),
        .err_count(err_count),
        .txn_count(txn_count)
    );

    // Reference add/sub: A + selected B + cin, 5-bit unsigned.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s, input logic c);
        logic [3:0] y;
        case (s)
            2'b00:   y = b;
            2'b01:   y = 4'hF ^ b;
            2'b10:   y = 4'h0;
            default: y = 4'hF;
        endcase
        return 5'(a) + 5'(y) + 5'(c);
    endfunction

    // Behavioural datapath driven by the DUT's registered operands.
    logic [4:0] dp_sum;
    assign dp_sum  = ref_alu(dp_a, dp_b, dp_s, dp_cin);
    assign dp_d    = stub ? 4'h0 : dp_sum[3:0];
    assign dp_cout = dp_sum[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare each result on the cycle it is handed downstream.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("out_d",    32'(out_d),    32'(e[3:0]));
                chk("out_cout", 32'(out_cout), 32'(e[4]));
                chk("out_err",  32'(out_err),  32'(e[5]));
            end
        end
    end

    // Issue one op, record its expected result and check result latency.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                        input logic c, input logic [3:0] ed, input logic ec, input logic ee);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_a = a; in_b = b; in_s = s; in_cin = c; in_valid = 1'b1;
        exp_q.push_back({ee, ec, ed});
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < SETTLE + 5) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", 32'(k), 32'(SETTLE));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drain();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] e;
        logic [10:0] v;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_s = '0; in_cin = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dp_a",      32'(dp_a),      32'd0);
        chk("rst_txn",       32'(txn_count), 32'd0);
        chk("rst_err",       32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed ops
        send(4'd5, 4'd3, 2'b00, 1'b0, 4'h8, 1'b0, 1'b0);
        send(4'd9, 4'd9, 2'b00, 1'b1, 4'h3, 1'b1, 1'b0);
        send(4'd5, 4'd3, 2'b01, 1'b1, 4'h2, 1'b1, 1'b0);
        send(4'd0, 4'd6, 2'b11, 1'b0, 4'hF, 1'b0, 1'b0);
        send(4'd0, 4'd6, 2'b11, 1'b1, 4'h0, 1'b1, 1'b0);

        // Output stall: result and handshake signals hold, input pulses ignored
        drain();
        out_ready = 1'b0;
        send(4'd7, 4'd2, 2'b00, 1'b0, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_s = 2'b10;
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_d",     32'(out_d),     32'h9);
            chk("stall_out_err",   32'(out_err),   32'd0);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_dp_a",      32'(dp_a),      32'd7);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_dp_a",     32'(dp_a),     32'd7);
        chk("post_txn",      32'(txn_count), 32'd6);

        // Exhaustive {cin,a,b,s} through the behavioural datapath
        do_reset();
        for (int i = 0; i < 2048; i++) begin
            v = 11'(i);
            e = ref_alu(v[9:6], v[5:2], v[1:0], v[10]);
            send(v[9:6], v[5:2], v[1:0], v[10], e[3:0], e[4], 1'b0);
        end
        drain();
        chk("exh_txn", 32'(txn_count), 32'd2048);
        chk("exh_err", 32'(err_count), 32'd0);

        // Reset in the middle of SETTLE
        do_reset();
        @(negedge clk);
        in_a = 4'd5; in_b = 4'd3; in_s = 2'b00; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dp_a",      32'(dp_a),      32'd0);
        chk("mid_rst_dp_cin",    32'(dp_cin),    32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_d",     32'(out_d),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(in_ready),  32'd1);
        chk("mid_rel_txn",      32'(txn_count), 32'd0);
        repeat (SETTLE + 2) @(posedge clk);
        #1 chk("mid_rel_no_out", 32'(out_valid), 32'd0);

        // Stubbed datapath: every op mismatches, counter saturates
        do_reset();
        stub = 1'b1;
        send(4'd1, 4'd1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1);
        drain();
        chk("stub_err_1", 32'(err_count), 32'd1);
        for (int i = 1; i < 300; i++) begin
            send(4'd1, 4'd1, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1);
        end
        drain();
        chk("stub_err_sat", 32'(err_count), 32'd255);
        chk("stub_txn",     32'(txn_count), 32'd300);
        stub = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
